// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: turns one command into an AW/W/B or AR/R
// transaction, with a per-transaction watchdog that forces a SLVERR-style response.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  BVALID,
  output logic                  BREADY,
  input  logic [1:0]            BRESP,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT_CYCLES);

  state_t                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [CW-1:0]         wd_cnt_q, wd_cnt_d;

  logic busy, expire, done_hs, aw_left, w_left;

  // Every channel transfers on the cycle where VALID and READY are both high at
  // the rising edge; VALID never waits on READY, payloads hold while VALID is pending.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    araddr_d      = araddr_q;
    wd_cnt_d      = wd_cnt_q;

    busy    = (state_q == WR_REQ) || (state_q == WR_RESP) ||
              (state_q == RD_REQ) || (state_q == RD_RESP);
    done_hs = ((state_q == WR_RESP) && BVALID && bready_q) ||
              ((state_q == RD_RESP) && RVALID && rready_q);
    expire  = (TIMEOUT_CYCLES != 0) && busy && (wd_cnt_q == TO_CNT);
    aw_left = awvalid_q && !AWREADY;
    w_left  = wvalid_q && !WREADY;

    // Saturating so a long-lived state can never wrap back below the limit.
    if (busy && (TIMEOUT_CYCLES != 0) && (wd_cnt_q != TO_CNT)) begin
      wd_cnt_d = wd_cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          wd_cnt_d      = '0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        awvalid_d = aw_left;
        wvalid_d  = w_left;
        if (!aw_left && !w_left) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end
      WR_RESP: begin
        if (BVALID && bready_q) begin
          bready_d    = 1'b0;
          rsp_resp_d  = BRESP;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (RVALID && rready_q) begin
          rready_d    = 1'b0;
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abandon the hung transaction; a B/R handshake in the same cycle wins.
    if (expire && !done_hs) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
      rsp_valid_d   = 1'b1;
      state_d       = RSP;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      araddr_q      <= '0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      araddr_q      <= araddr_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign AWVALID     = awvalid_q;
  assign WVALID      = wvalid_q;
  assign BREADY      = bready_q;
  assign ARVALID     = arvalid_q;
  assign RREADY      = rready_q;
  assign AWADDR      = awaddr_q;
  assign WDATA       = wdata_q;
  assign ARADDR      = araddr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: the bench plays the AXI slave cycle by
// cycle and checks channel timing, response contents, watchdog and reset.
module tb_axi_lite_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic [1:0]    bresp, rresp;
  logic [2:0]    dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW+2:0] exp_q[$];

  axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWVALID(awvalid), .AWREADY(awready), .AWADDR(awaddr),
    .WVALID(wvalid), .WREADY(wready), .WDATA(wdata),
    .BVALID(bvalid), .BREADY(bready), .BRESP(bresp),
    .ARVALID(arvalid), .ARREADY(arready), .ARADDR(araddr),
    .RVALID(rvalid), .RREADY(rready), .RDATA(rdata), .RRESP(rresp),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks; every call starts and ends just after a falling edge.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    check("cmd_ready_before_accept", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag);
    logic [DW+2:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1'b0, 1'b1);
    end else begin
      e = exp_q.pop_front();
      check(tag, {rsp_timeout, rsp_resp, rsp_rdata}, e);
    end
  endtask

  task automatic consume_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_consume", rsp_valid, 1'b0);
    check("cmd_ready_after_consume", cmd_ready, 1'b1);
  endtask

  task automatic wait_rsp(input int max_cycles);
    int n = 0;
    while (!rsp_valid && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("wait_rsp_bound", rsp_valid, 1'b1);
  endtask

  initial begin
    logic hold_ok;
    logic [DW-1:0] held;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    check("reset_payload", {awaddr, wdata, araddr, rsp_rdata, rsp_resp, rsp_timeout}, '0);
    check("reset_state", dbg_state, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: always-ready write
    awready = 1'b1; wready = 1'b1;
    send_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF);
    check("w1_c1_valids", {awvalid, wvalid, bready}, 3'b110);
    check("w1_c1_awaddr", awaddr, 32'h0000_0004);
    check("w1_c1_wdata", wdata, 32'hDEAD_BEEF);
    check("w1_c1_cmd_ready", cmd_ready, 1'b0);
    bvalid = 1'b1; bresp = 2'b00;
    @(negedge clk);
    check("w1_c2_valids", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
    @(negedge clk);
    bvalid = 1'b0;
    exp_q.push_back({1'b0, 2'b00, 32'h0});
    check("w1_c3_rsp_valid", rsp_valid, 1'b1);
    check("w1_c3_bready", bready, 1'b0);
    check_rsp("w1_rsp");
    consume_rsp();

    // 2: W accepted first, AW held until cycle 4
    awready = 1'b0; wready = 1'b1;
    send_cmd(1'b1, 32'h0000_0020, 32'h0BAD_F00D);
    check("w2_c1_valids", {awvalid, wvalid}, 2'b11);
    hold_ok = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      if (c == 4) awready = 1'b1;
      if (!(awvalid && !wvalid && !bready && awaddr == 32'h0000_0020)) hold_ok = 1'b0;
    end
    check("w2_aw_hold_w_clear", hold_ok, 1'b1);
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    check("w2_c5_bready", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1'b1; bresp = 2'b01;
    @(negedge clk);
    bvalid = 1'b0;
    exp_q.push_back({1'b0, 2'b01, 32'h0});
    check_rsp("w2_rsp");
    consume_rsp();

    // 3+4: read with delayed AR and R, then stalled response consumer
    send_cmd(1'b0, 32'h0000_0008, 32'h0);
    check("r1_c1_ar", {arvalid, rready, araddr}, {1'b1, 1'b0, 32'h0000_0008});
    @(negedge clk);
    check("r1_c2_ar_hold", {arvalid, rready, araddr}, {1'b1, 1'b0, 32'h0000_0008});
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("r1_c3_rready", {arvalid, rready}, 2'b01);
    repeat (3) @(negedge clk);
    rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0; rdata = '0;
    check("r1_rready_clear", rready, 1'b0);
    exp_q.push_back({1'b0, 2'b00, 32'h1234_5678});
    check_rsp("r1_rsp");
    held = rsp_rdata;
    hold_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_rdata == 32'h1234_5678 && !cmd_ready)) hold_ok = 1'b0;
    end
    check("r1_rsp_stable_stall", hold_ok, 1'b1);
    rsp_ready = 1'b1;
    check("r1_cmd_ready_in_hs", cmd_ready, 1'b0);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("r1_after_hs", {rsp_valid, cmd_ready}, 2'b01);

    // 5: watchdog on a write whose AW/W never handshake
    send_cmd(1'b1, 32'h0000_0040, 32'hFFFF_0000);
    hold_ok = 1'b1;
    for (int c = 1; c <= TO + 1; c++) begin
      if (!(awvalid && wvalid && !rsp_valid)) hold_ok = 1'b0;
      @(negedge clk);
    end
    check("to_valid_held", hold_ok, 1'b1);
    check("to_valids_drop", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("to_rsp_valid", rsp_valid, 1'b1);
    exp_q.push_back({1'b1, 2'b10, 32'h0});
    check_rsp("to_rsp");
    consume_rsp();
    check("to_flag_persists", rsp_timeout, 1'b1);
    arready = 1'b1;
    send_cmd(1'b0, 32'h0000_0044, 32'h0);
    check("r2_timeout_cleared", rsp_timeout, 1'b0);
    @(negedge clk);
    arready = 1'b0;
    check("r2_c2_rready", rready, 1'b1);
    rvalid = 1'b1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
    @(negedge clk);
    rvalid = 1'b0;
    exp_q.push_back({1'b0, 2'b00, 32'hCAFE_F00D});
    check_rsp("r2_rsp");
    consume_rsp();

    // 6: reset while waiting in WR_RESP
    awready = 1'b1; wready = 1'b1;
    send_cmd(1'b1, 32'h0000_0010, 32'h0000_55AA);
    @(negedge clk);
    check("rst_in_wr_resp", {dbg_state, bready}, {3'd2, 1'b1});
    rst_n = 1'b0;
    #1;
    check("rst_async_valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 6'b0);
    check("rst_async_state", dbg_state, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_cmd_ready", cmd_ready, 1'b1);
    bvalid = 1'b1; bresp = 2'b00;
    send_cmd(1'b1, 32'h0000_0010, 32'h0000_55AA);
    check("w3_c1_payload", {awaddr, wdata}, {32'h0000_0010, 32'h0000_55AA});
    wait_rsp(TO + 4);
    bvalid = 1'b0;
    exp_q.push_back({1'b0, 2'b00, 32'h0});
    check_rsp("w3_rsp");
    consume_rsp();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI-Lite initiator. Converts a simple command/response interface into AXI-Lite write (AW/W/B) and read (AR/R) transactions.
- Drives the slave port of top_soc from a test sequencer, DMA stub or future CPU shim.
- Includes a per-transaction watchdog, so a hung slave cannot stall the command side forever.

Parameters:
- ADDR_WIDTH, 32, AXI/command address width
- DATA_WIDTH, 32, AXI/command data width
- TIMEOUT_CYCLES, 256, cycles allowed from command acceptance to B/R handshake; 0 disables the watchdog

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout
- rsp_timeout  out  1  response produced by the watchdog
- AWVALID out 1, AWREADY in 1, AWADDR out ADDR_WIDTH
- WVALID out 1, WREADY in 1, WDATA out DATA_WIDTH
- BVALID in 1, BREADY out 1, BRESP in 2
- ARVALID out 1, ARREADY in 1, ARADDR out ADDR_WIDTH
- RVALID in 1, RREADY out 1, RDATA in DATA_WIDTH, RRESP in 2

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE
  - all VALID/READY outputs 0, except cmd_ready=1
  - AWADDR, WDATA, ARADDR, rsp_rdata, rsp_resp = 0
  - rsp_timeout = 0
  - watchdog counter = 0
- All outputs are registered. cmd_ready is high only in IDLE.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_valid&&cmd_ready captures addr/data.
  - Write: next cycle AWVALID=WVALID=1 with AWADDR/WDATA, state WR_REQ.
  - Read: ARVALID=1 with ARADDR, state RD_REQ.
- WR_REQ:
  - AWVALID and WVALID each clear independently on their own handshake. Either may complete first, or both in the same cycle.
  - A handshaked channel is never re-asserted.
  - When both are done, BREADY=1 in the following cycle, state WR_RESP.
- WR_RESP: on BVALID&&BREADY, BREADY=0, rsp_resp=BRESP, rsp_rdata=0, state RSP.
- RD_REQ: on ARVALID&&ARREADY, ARVALID=0, RREADY=1 next cycle, state RD_RESP.
- RD_RESP: on RVALID&&RREADY, RREADY=0, rsp_rdata=RDATA, rsp_resp=RRESP, state RSP.
- RSP:
  - rsp_valid=1, with rsp_* stable until rsp_ready.
  - On rsp_valid&&rsp_ready, rsp_valid=0, state IDLE, cmd_ready=1 next cycle.
  - No new command is accepted in the handshake cycle.
- AXI stability: while any VALID is high and unacknowledged, its address and data are held constant.
- VALID is never gated on READY. READY (BREADY/RREADY) is never asserted before the request phase completes.
- Watchdog:
  - Counter clears on command acceptance and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - At count==TIMEOUT_CYCLES with no completing handshake in that cycle: all AXI VALID/READY drop to 0, rsp_resp=2'b10, rsp_rdata=0, rsp_timeout=1, state RSP.
  - This is deliberate fault recovery; the abandoned transaction is not retried.
  - A handshake in the same cycle as expiry wins, and the normal response is used.
  - rsp_timeout clears on the next accepted command.
- Latency with an always-ready slave:
  - Write: cmd accept at cycle 0, AW/W handshake at 1, BREADY at 2, B handshake at 2 if BVALID, rsp_valid at 3.
  - Read: AR handshake at 1, RREADY at 2, rsp_valid at 3 if RVALID at 2.
- Reset asserted mid-transaction: immediate return to reset values; any partial AXI transaction is abandoned.

Test Plan:
- Write 0x0000_0004 ← 0xDEAD_BEEF, slave always ready with BRESP=0 -> AWVALID/WVALID high cycle 1 with that addr/data; rsp_valid cycle 3, rsp_resp=2'b00, rsp_timeout=0.
- Write with WREADY at cycle 1, AWREADY delayed to cycle 4 -> WVALID low from cycle 2; AWVALID held with stable AWADDR through cycle 4; BREADY first high at cycle 5.
- Read 0x0000_0008, slave returns RDATA=0x1234_5678, RRESP=2'b00 after 3 wait cycles -> rsp_rdata=0x1234_5678; ARADDR stable until ARREADY; RREADY only after the AR handshake.
- rsp_ready held low 5 cycles after a read -> rsp_valid/rsp_rdata stable; cmd_ready stays 0 until the cycle after rsp_ready.
- TIMEOUT_CYCLES=16, slave never asserts AWREADY -> at count 16 AWVALID/WVALID drop, rsp_resp=2'b10, rsp_timeout=1; the next read completes normally with rsp_timeout=0.
- ARESETN low while in WR_RESP -> all VALID/READY 0 immediately, cmd_ready=1 after release; a subsequent write completes normally.
